// File: rtl/count_ones_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_ones_pkg
// Description : Shared helpers for the pipelined population counter:
//               ceiling log2, beat sideband struct and saturating add.
// Revision    : 1.0 - initial release
// ============================================================================
package count_ones_pkg;

  // Widest accumulator the saturating adder supports.
  localparam int MAX_TOTAL_WIDTH = 32;

  localparam logic [MAX_TOTAL_WIDTH:0] SAT_ONE = {{MAX_TOTAL_WIDTH{1'b0}}, 1'b1};

  // Sideband carried alongside each beat through the pipeline.
  typedef struct packed {
    logic last;
    logic accumulate;
  } side_t;

  // Smallest r such that 2**r >= value.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Saturating add at total_width bits. Returns {ovf, total}; total bits
  // above total_width are always zero.
  function automatic logic [MAX_TOTAL_WIDTH:0] sat_add(
    input logic [MAX_TOTAL_WIDTH-1:0] acc,
    input logic [MAX_TOTAL_WIDTH-1:0] count,
    input int                         total_width
  );
    logic [MAX_TOTAL_WIDTH:0] sum;
    logic [MAX_TOTAL_WIDTH:0] limit;
    logic                     ovf;
    sum   = {1'b0, acc} + {1'b0, count};
    limit = (SAT_ONE << total_width) - SAT_ONE;
    ovf   = (sum > limit);
    return {ovf, (ovf ? limit[MAX_TOTAL_WIDTH-1:0] : sum[MAX_TOTAL_WIDTH-1:0])};
  endfunction

endpackage
`default_nettype wire

// File: rtl/count_ones_chunk.sv
`default_nettype none
// ============================================================================
// Module      : count_ones_chunk
// Description : Combinational population count of one CHUNK_WIDTH leaf.
// Revision    : 1.0 - initial release
// ============================================================================
module count_ones_chunk
  import count_ones_pkg::*;
#(
  parameter int CHUNK_WIDTH = 8,
  parameter int CNT_WIDTH   = clog2(CHUNK_WIDTH + 1)
) (
  input  logic [CHUNK_WIDTH-1:0] data,
  output logic [CNT_WIDTH-1:0]   count
);

  // Ripple sum of the leaf bits; small enough to stay within one stage.
  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      count = count + CNT_WIDTH'(data[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/count_ones_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : count_ones_pipelined
// Description : Two-stage streaming population counter with valid/ready
//               backpressure and an optional saturating per-packet total.
// Revision    : 1.0 - initial release
// ============================================================================
module count_ones_pipelined
  import count_ones_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int CHUNK_WIDTH = 8,
  parameter int TOTAL_WIDTH = 16,
  parameter int COUNT_WIDTH = clog2(WIDTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  input  logic                   in_accumulate,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic [TOTAL_WIDTH-1:0] out_total,
  output logic                   out_overflow,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int NUM_CHUNKS  = WIDTH / CHUNK_WIDTH;
  localparam int CHUNK_CNT_W = clog2(CHUNK_WIDTH + 1);

  logic [CHUNK_CNT_W-1:0] chunk_counts [NUM_CHUNKS];
  logic [CHUNK_CNT_W-1:0] s1_counts    [NUM_CHUNKS];
  side_t                  s1_side;
  logic                   s1_valid;

  logic                   s1_load;
  logic                   s2_load;
  logic [COUNT_WIDTH-1:0] sum_count;

  logic [TOTAL_WIDTH-1:0] acc;
  logic                   acc_ovf;
  logic [MAX_TOTAL_WIDTH:0] sat_res;
  logic [TOTAL_WIDTH-1:0] total;
  logic                   ovf;
  logic                   unused_sat;

  // Handshake: S2 frees when empty or drained; S1 frees when it can move on.
  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign s1_load  = in_valid & in_ready;

  generate
    for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_chunk
      count_ones_chunk #(
        .CHUNK_WIDTH (CHUNK_WIDTH),
        .CNT_WIDTH   (CHUNK_CNT_W)
      ) u_chunk (
        .data  (in_data[g*CHUNK_WIDTH +: CHUNK_WIDTH]),
        .count (chunk_counts[g])
      );
    end
  endgenerate

  // Stage 1: capture leaf counts and sideband of the accepted beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_side  <= '0;
      for (int i = 0; i < NUM_CHUNKS; i++) s1_counts[i] <= '0;
    end else begin
      if (s1_load) begin
        s1_valid           <= 1'b1;
        s1_side.last       <= in_last;
        s1_side.accumulate <= in_accumulate;
        for (int i = 0; i < NUM_CHUNKS; i++) s1_counts[i] <= chunk_counts[i];
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Adder tree over the registered leaf counts plus saturating accumulate.
  always_comb begin
    sum_count = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      sum_count = sum_count + COUNT_WIDTH'(s1_counts[i]);
    end
    sat_res = sat_add(MAX_TOTAL_WIDTH'(acc), MAX_TOTAL_WIDTH'(sum_count), TOTAL_WIDTH);
    total   = sat_res[TOTAL_WIDTH-1:0];
    ovf     = acc_ovf | sat_res[MAX_TOTAL_WIDTH];
  end

  assign unused_sat = ^sat_res;

  // Stage 2: result registers; hold while stalled downstream.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_count    <= '0;
      out_total    <= '0;
      out_overflow <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid    <= 1'b1;
        out_count    <= sum_count;
        out_total    <= s1_side.accumulate ? total : TOTAL_WIDTH'(sum_count);
        out_overflow <= s1_side.accumulate & ovf;
        out_last     <= s1_side.last;
      end else if (out_ready) begin
        out_valid    <= 1'b0;
      end
    end
  end

  // Running total; standalone beats leave it untouched, last beats clear it.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (s2_load && s1_side.accumulate) begin
      if (s1_side.last) begin
        acc     <= '0;
        acc_ovf <= 1'b0;
      end else begin
        acc     <= total;
        acc_ovf <= ovf;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_count_ones_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_ones_pipelined
// Description : Directed-vector scoreboard bench for count_ones_pipelined
//               (WIDTH 32, CHUNK_WIDTH 8, TOTAL_WIDTH 6 so saturation is
//               reachable with a few beats).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_ones_pipelined;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_accumulate;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  out_count;
  logic [5:0]  out_total;
  logic        out_overflow;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    int cnt;
    int tot;
    bit ovf;
    bit last;
  } exp_t;

  exp_t expq[$];
  int   checks_total  = 0;
  int   checks_passed = 0;
  int   stall_seen    = 0;

  count_ones_pipelined #(
    .WIDTH       (32),
    .CHUNK_WIDTH (8),
    .TOTAL_WIDTH (6)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_accumulate (in_accumulate),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_count     (out_count),
    .out_total     (out_total),
    .out_overflow  (out_overflow),
    .out_last      (out_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint req);
    checks_total++;
    if (act == req) checks_passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Present one beat until accepted; optionally queue its expected result.
  task automatic send(input logic [31:0] d, input logic l, input logic a,
                      input int ec, input int et, input bit eo, input bit push);
    int guard;
    exp_t e;
    in_data       = d;
    in_last       = l;
    in_accumulate = a;
    in_valid      = 1'b1;
    guard         = 0;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      stall_seen++;
      guard++;
      if (guard > 50) begin
        checks_total++;
        $display("FAIL send_timeout: beat 0x%08h not accepted within 50 cycles", d);
        break;
      end
    end
    if (push) begin
      e.cnt = ec; e.tot = et; e.ovf = eo; e.last = l;
      expq.push_back(e);
    end
    @(posedge clock);
    #1;
    in_valid      = 1'b0;
    in_data       = 32'hDEAD_BEEF;
    in_last       = 1'b1;
    in_accumulate = 1'b1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (expq.size() != 0 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (expq.size() != 0) begin
      checks_total++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", expq.size());
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare every output handshake against the scoreboard.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks_total++;
        $display("FAIL unexpected_output: count %0d total %0d with empty scoreboard",
                 out_count, out_total);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("out_count",    out_count,    e.cnt);
        check("out_total",    out_total,    e.tot);
        check("out_overflow", out_overflow, e.ovf);
        check("out_last",     out_last,     e.last);
      end
    end
  end

  initial begin
    reset         = 1'b1;
    in_data       = '0;
    in_last       = 1'b0;
    in_accumulate = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_out_valid",    out_valid,    0);
    check("rst_in_ready",     in_ready,     1);
    check("rst_out_count",    out_count,    0);
    check("rst_out_total",    out_total,    0);
    check("rst_out_overflow", out_overflow, 0);
    check("rst_out_last",     out_last,     0);
    @(posedge clock);
    #1;

    // Single beat and two-cycle latency
    send(32'hFFFF_FFFF, 1'b0, 1'b0, 32, 32, 1'b0, 1'b1);
    @(negedge clock);
    check("latency_not_early", out_valid, 0);
    @(negedge clock);
    check("latency_valid", out_valid, 1);
    drain();

    // Back-to-back at full rate
    stall_seen = 0;
    send(32'h0000_0001, 1'b0, 1'b0, 1,  1,  1'b0, 1'b1);
    send(32'h8000_0001, 1'b0, 1'b0, 2,  2,  1'b0, 1'b1);
    send(32'h0F0F_0F0F, 1'b0, 1'b0, 16, 16, 1'b0, 1'b1);
    check("b2b_no_stall", stall_seen, 0);
    drain();

    // Packet 5,7,3 with an interleaved standalone beat, then a fresh packet
    send(32'h0000_001F, 1'b0, 1'b1, 5, 5,  1'b0, 1'b1);
    send(32'h0000_0003, 1'b0, 1'b0, 2, 2,  1'b0, 1'b1);
    send(32'h0000_007F, 1'b0, 1'b1, 7, 12, 1'b0, 1'b1);
    send(32'h0000_0007, 1'b1, 1'b1, 3, 15, 1'b0, 1'b1);
    send(32'h0000_000F, 1'b1, 1'b1, 4, 4,  1'b0, 1'b1);
    drain();

    // Saturation at 6 bits, cleared by the last beat
    send(32'hFFFF_FFFF, 1'b0, 1'b1, 32, 32, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 1'b0, 1'b1, 32, 63, 1'b1, 1'b1);
    send(32'hFFFF_FFFF, 1'b1, 1'b1, 32, 63, 1'b1, 1'b1);
    send(32'h0000_0001, 1'b1, 1'b1, 1,  1,  1'b0, 1'b1);
    drain();

    // Backpressure: two beats fill the pipe, third is refused, outputs hold
    out_ready = 1'b0;
    send(32'h0000_0001, 1'b0, 1'b0, 1, 1, 1'b0, 1'b1);
    send(32'h0000_0003, 1'b0, 1'b0, 2, 2, 1'b0, 1'b1);
    in_data  = 32'h0000_0007;
    in_last  = 1'b0;
    in_accumulate = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_in_ready_low", in_ready,  0);
      check("bp_hold_valid",   out_valid, 1);
      check("bp_hold_count",   out_count, 1);
      check("bp_hold_total",   out_total, 1);
      @(posedge clock);
    end
    #1 out_ready = 1'b1;
    send(32'h0000_0007, 1'b0, 1'b0, 3, 3, 1'b0, 1'b1);
    send(32'h0000_000F, 1'b0, 1'b0, 4, 4, 1'b0, 1'b1);
    drain();

    // Reset with acc = 20 and two beats in flight
    send(32'h0000_FFFF, 1'b0, 1'b1, 16, 16, 1'b0, 1'b1);
    send(32'h0000_000F, 1'b0, 1'b1, 4,  20, 1'b0, 1'b1);
    drain();
    out_ready = 1'b0;
    send(32'h0000_0001, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    send(32'h0000_0001, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready",  in_ready,  1);
    @(posedge clock);
    #1;
    send(32'h0000_0007, 1'b1, 1'b1, 3, 3, 1'b0, 1'b1);
    drain();

    check("scoreboard_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
